spi_slot_arbiter: RTL and testbench
===================================

// Module: spi_slot_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one SPI shift engine among NUM_REQ
//  register-slot requesters of the PL SPI parallel AXI4-Lite peripheral.
//  Sits between the AXI-Lite register file (requests, status) and the SPI
//  engine (start/done). Serialises transfers, enforces a chip-select gap and
//  recovers from a hung engine with a timeout.
// PARAMETERS
//  NUM_REQ  4     number of requesters; power of 2, >=2
//  DATA_W   32    transfer word width
//  CS_GAP   4     idle cycles between engine transfers; 0 = no gap
//  TIMEOUT  1024  cycles in WAIT before abort; >=2
// PORTS
//  s00_axi_aclk     in   1                clock
//  s00_axi_aresetn  in   1                async active-low reset
//  enable           in   1                control bit; 0 = grant no new requests
//  req_valid        in   NUM_REQ          per-slot pending request (level)
//  req_data         in   NUM_REQ*DATA_W   slot k word at [k*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ          one-hot 1-cycle accept pulse
//  rsp_valid        out  1                1-cycle response pulse
//  rsp_id           out  clog2(NUM_REQ)   slot the response belongs to
//  rsp_data         out  DATA_W           received word (0 on timeout)
//  rsp_timeout      out  1                qualifies rsp_valid: transfer aborted
//  eng_start        out  1                1-cycle engine start pulse
//  eng_abort        out  1                1-cycle engine abort pulse
//  eng_cs_sel       out  clog2(NUM_REQ)   chip-select index for engine
//  eng_tx           out  DATA_W           word to shift out
//  eng_done         in   1                1-cycle engine completion pulse
//  eng_rx           in   DATA_W           received word, valid with eng_done
//  busy             out  1                1 in any state other than IDLE
//  timeout_cnt      out  8                saturating abort count
// BEHAVIOUR
//  - All outputs registered. Reset: all outputs 0, state IDLE, last_grant =
//    NUM_REQ-1 so the first grant goes to slot 0. Reset mid-operation aborts
//    silently: no rsp_valid, no eng_abort.
//  - FSM IDLE -> START -> WAIT -> GAP -> IDLE.
//  - IDLE: if enable & |req_valid, select first set slot searching from
//    last_grant+1 (wrapping). Assert req_ready[k] one cycle, latch req_data
//    slot k into eng_tx, set eng_cs_sel=k, last_grant=k -> START.
//  - START: eng_start=1 for exactly one cycle; clear WAIT counter -> WAIT.
//  - WAIT: counter +1 per cycle. If eng_done: next cycle rsp_valid=1,
//    rsp_id=k, rsp_data=eng_rx, rsp_timeout=0 -> GAP. Otherwise, when the
//    counter reaches TIMEOUT-1: next cycle rsp_valid=1, rsp_timeout=1,
//    rsp_data=0, eng_abort=1, timeout_cnt+1 (saturate at 255) -> GAP.
//    done and timeout in the same cycle: done wins, normal response.
//  - GAP: hold CS_GAP cycles, then IDLE. CS_GAP=0: WAIT goes directly to IDLE.
//  - Latency: accept at cycle T, eng_start at T+1, rsp_valid at D+1 where D
//    is the eng_done cycle. Minimum eng_start spacing = transfer + CS_GAP + 2.
//  - eng_done outside WAIT is ignored. enable=0 mid-transfer: current transfer
//    completes normally; no further grants. req_valid dropped after
//    acceptance has no effect on the transfer in flight.
//  - Requester releases req_valid after req_ready; still-high req_valid after
//    the transfer is a new request.
// TESTING
//  1 Reset: all outputs 0, busy=0; release reset with req_valid=4'b1111 ->
//    first req_ready=4'b0001.
//  2 Single: req_valid[1]=1, data 0xA5A50001; engine done after 10 cycles with
//    rx 0x12345678 -> req_ready=0010, eng_start with cs_sel=1 tx=0xA5A50001,
//    rsp_valid id=1 data=0x12345678 timeout=0.
//  3 Fairness: req_valid=1111 held -> grant order 0,1,2,3,0; >=CS_GAP idle
//    cycles between each rsp_valid and the next req_ready.
//  4 Timeout: engine never done -> rsp_valid timeout=1 data=0 exactly TIMEOUT
//    cycles after eng_start, eng_abort pulse, timeout_cnt=1; next request served.
//  5 Race: eng_done at the counter's TIMEOUT-1 cycle -> normal response,
//    timeout_cnt unchanged.
//  6 enable=0 with pending reqs -> no req_ready; assert reset in WAIT -> no
//    rsp_valid, next grant is slot 0.

Source files
------------

// File: rtl/spi_slot_arbiter_if.sv
// spi_slot_arbiter_if: bundles the requester, response and SPI-engine signals of spi_slot_arbiter
//   slave  : arbiter side (takes enable/requests/engine status, drives grants/responses/engine control)
//   master : register-file + SPI-engine side (the mirror image)
interface spi_slot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_timeout;
  logic                      eng_start;
  logic                      eng_abort;
  logic [ID_W-1:0]           eng_cs_sel;
  logic [DATA_W-1:0]         eng_tx;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_rx;
  logic                      busy;
  logic [7:0]                timeout_cnt;
  modport slave (
    input  enable, req_valid, req_data, eng_done, eng_rx,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
           eng_start, eng_abort, eng_cs_sel, eng_tx, busy, timeout_cnt
  );
  modport master (
    output enable, req_valid, req_data, eng_done, eng_rx,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
           eng_start, eng_abort, eng_cs_sel, eng_tx, busy, timeout_cnt
  );
endinterface

// File: rtl/spi_slot_arbiter.sv
// spi_slot_arbiter: round-robin sequencer sharing one SPI shift engine among NUM_REQ slots
//   s00_axi_aclk    clock
//   s00_axi_aresetn async active-low reset
//   bus             spi_slot_arbiter_if.slave (requests, responses, engine control/status)
module spi_slot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CS_GAP  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic               s00_axi_aclk,
  input logic               s00_axi_aresetn,
  spi_slot_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = $clog2((TIMEOUT > CS_GAP ? TIMEOUT : CS_GAP) + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t              r_state, w_state;
  logic [ID_W-1:0]     r_last, w_last, w_pick;
  logic [ID_W-1:0]     r_cs_sel, w_cs_sel, r_rsp_id, w_rsp_id;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [NUM_REQ-1:0]  r_req_ready, w_req_ready;
  logic                r_rsp_valid, w_rsp_valid, r_rsp_timeout, w_rsp_timeout;
  logic                r_eng_start, w_eng_start, r_eng_abort, w_eng_abort;
  logic                r_busy, w_busy;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data, r_eng_tx, w_eng_tx;
  logic [7:0]          r_tcnt, w_tcnt;
  logic                w_finish;
  // Scan offsets from far to near so the closest set slot after r_last wins;
  // the NUM_REQ power-of-2 constraint makes the ID_W truncation the wrap-around.
  always_comb begin
    w_pick = r_last;
    for (int i = NUM_REQ; i >= 1; i--)
      if (bus.req_valid[ID_W'(int'(r_last) + i)]) w_pick = ID_W'(int'(r_last) + i);
  end
  // done has priority over the timeout on the same cycle
  assign w_finish = bus.eng_done || (r_cnt == CW'(TIMEOUT - 1));
  always_comb begin
    w_state       = r_state;
    w_last        = r_last;
    w_cnt         = r_cnt;
    w_cs_sel      = r_cs_sel;
    w_eng_tx      = r_eng_tx;
    w_rsp_id      = r_rsp_id;
    w_rsp_data    = r_rsp_data;
    w_tcnt        = r_tcnt;
    w_req_ready   = '0;
    w_rsp_valid   = 1'b0;
    w_rsp_timeout = 1'b0;
    w_eng_start   = 1'b0;
    w_eng_abort   = 1'b0;
    case (r_state)
      IDLE: if (bus.enable && |bus.req_valid) begin
        w_req_ready = NUM_REQ'(1) << w_pick;
        w_last      = w_pick;
        w_cs_sel    = w_pick;
        w_eng_tx    = bus.req_data[int'(w_pick)*DATA_W +: DATA_W];
        w_state     = START;
      end
      START: begin
        w_eng_start = 1'b1;
        w_cnt       = '0;
        w_state     = WAIT;
      end
      WAIT: begin
        w_cnt = r_cnt + 1'b1;
        if (w_finish) begin
          w_rsp_valid   = 1'b1;
          w_rsp_id      = r_cs_sel;
          w_rsp_timeout = !bus.eng_done;
          w_rsp_data    = bus.eng_done ? bus.eng_rx : '0;
          w_eng_abort   = !bus.eng_done;
          w_tcnt        = (!bus.eng_done && r_tcnt != 8'hff) ? r_tcnt + 8'd1 : r_tcnt;
          w_cnt         = '0;
          w_state       = (CS_GAP == 0) ? IDLE : GAP;
        end
      end
      default: begin
        w_cnt   = r_cnt + 1'b1;
        w_state = (r_cnt == CW'(CS_GAP - 1)) ? IDLE : GAP;
      end
    endcase
    w_busy = (w_state != IDLE);
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state       <= IDLE;
      r_last        <= ID_W'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_cs_sel      <= '0;
      r_eng_tx      <= '0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_tcnt        <= '0;
      r_req_ready   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_eng_start   <= 1'b0;
      r_eng_abort   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_last        <= w_last;
      r_cnt         <= w_cnt;
      r_cs_sel      <= w_cs_sel;
      r_eng_tx      <= w_eng_tx;
      r_rsp_id      <= w_rsp_id;
      r_rsp_data    <= w_rsp_data;
      r_tcnt        <= w_tcnt;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_timeout <= w_rsp_timeout;
      r_eng_start   <= w_eng_start;
      r_eng_abort   <= w_eng_abort;
      r_busy        <= w_busy;
    end
  end
  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.eng_start   = r_eng_start;
  assign bus.eng_abort   = r_eng_abort;
  assign bus.eng_cs_sel  = r_cs_sel;
  assign bus.eng_tx      = r_eng_tx;
  assign bus.busy        = r_busy;
  assign bus.timeout_cnt = r_tcnt;
endmodule

// File: tb/tb_spi_slot_arbiter.sv
// tb_spi_slot_arbiter: directed + randomized self-checking bench for spi_slot_arbiter
module tb_spi_slot_arbiter;
  localparam int N = 4, DW = 32, GAP = 4, TO = 40;
  logic clk = 1'b0, rst_n = 1'b0;
  int   errs = 0, checks = 0, cyc = 0, rsp_cyc = -1, last_g = N - 1, exp_tcnt = 0;
  logic [DW-1:0] slot_data [N];
  spi_slot_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  spi_slot_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CS_GAP(GAP), .TIMEOUT(TO)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic set_data();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = slot_data[i];
  endtask
  // Round-robin rule: first pending slot after the previous grant, wrapping.
  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int off = 1; off <= N; off++) if (v[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction
  // delay: cycles from the eng_start cycle to eng_done (<0 = engine hangs)
  task automatic run_xfer(input int delay, input logic [DW-1:0] rx, input bit drop,
                          input bit dis, output int got);
    int exp_k, w;
    exp_k = rr_pick(last_g, bus.req_valid);
    w = 0;
    while (bus.req_ready == '0 && w < 300) begin tick(); w++; end
    chk("grant_seen", bus.req_ready != '0, 1);
    chk("req_ready", bus.req_ready, N'(1) << exp_k);
    chk("busy_on_grant", bus.busy, 1);
    if (rsp_cyc >= 0) chk("cs_gap_ok", (cyc - rsp_cyc - 1) >= GAP, 1);
    got = exp_k;
    last_g = exp_k;
    if (drop) bus.req_valid[exp_k] = 1'b0;
    if (dis) bus.enable = 1'b0;
    tick();
    chk("eng_start", bus.eng_start, 1);
    chk("eng_cs_sel", bus.eng_cs_sel, exp_k);
    chk("eng_tx", bus.eng_tx, slot_data[exp_k]);
    if (delay >= 0) begin
      for (int c = 0; c < delay; c++) begin
        tick();
        chk("no_early_rsp", bus.rsp_valid, 0);
      end
      bus.eng_done = 1'b1;
      bus.eng_rx = rx;
      tick();
      bus.eng_done = 1'b0;
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_id", bus.rsp_id, exp_k);
      chk("rsp_data", bus.rsp_data, rx);
      chk("rsp_timeout", bus.rsp_timeout, 0);
      chk("no_abort", bus.eng_abort, 0);
    end else begin
      for (int c = 1; c < TO; c++) begin
        tick();
        chk("no_rsp_before_to", bus.rsp_valid, 0);
      end
      tick();
      exp_tcnt = exp_tcnt < 255 ? exp_tcnt + 1 : 255;
      chk("to_rsp_valid", bus.rsp_valid, 1);
      chk("to_rsp_id", bus.rsp_id, exp_k);
      chk("to_rsp_timeout", bus.rsp_timeout, 1);
      chk("to_rsp_data", bus.rsp_data, 0);
      chk("to_eng_abort", bus.eng_abort, 1);
    end
    chk("timeout_cnt", bus.timeout_cnt, exp_tcnt);
    rsp_cyc = cyc;
  endtask
  initial begin
    int k, exp_k, w;
    int order [5] = '{0, 1, 2, 3, 0};
    bus.enable = 1'b1;
    bus.req_valid = '0;
    bus.eng_done = 1'b0;
    bus.eng_rx = '0;
    for (int i = 0; i < N; i++) slot_data[i] = 32'h1000_0000 + i;
    set_data();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_abort", bus.eng_abort, 0);
    chk("rst_eng_cs_sel", bus.eng_cs_sel, 0);
    chk("rst_eng_tx", bus.eng_tx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_cnt", bus.timeout_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_xfer(3 + i, 32'hC0DE_0000 + i, 1'b0, 1'b0, k);
      chk("fair_order", k, order[i]);
    end
    slot_data[1] = 32'hA5A5_0001;
    set_data();
    bus.req_valid = 4'b0010;
    run_xfer(10, 32'h1234_5678, 1'b1, 1'b0, k);
    chk("single_slot", k, 1);
    bus.req_valid = 4'b0100;
    run_xfer(-1, '0, 1'b1, 1'b0, k);
    chk("timeout_slot", k, 2);
    bus.req_valid = 4'b1000;
    run_xfer(5, 32'h0BAD_F00D, 1'b1, 1'b0, k);
    chk("after_to_slot", k, 3);
    bus.req_valid = 4'b0001;
    run_xfer(TO - 1, 32'h5A5A_A5A5, 1'b1, 1'b0, k);
    chk("race_slot", k, 0);
    bus.enable = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      bus.eng_done = (c == 10);
      bus.eng_rx = 32'hDEAD_BEEF;
      tick();
      chk("dis_no_ready", bus.req_ready, 0);
      chk("idle_done_ignored", bus.rsp_valid, 0);
    end
    bus.eng_done = 1'b0;
    chk("dis_idle_busy", bus.busy, 0);
    bus.enable = 1'b1;
    run_xfer(6, 32'h7777_0001, 1'b0, 1'b1, k);
    chk("dis_mid_slot", k, 1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("dis_mid_no_ready", bus.req_ready, 0);
    end
    bus.enable = 1'b1;
    exp_k = rr_pick(last_g, bus.req_valid);
    w = 0;
    while (bus.req_ready == '0 && w < 300) begin tick(); w++; end
    chk("rst_wait_grant", bus.req_ready, N'(1) << exp_k);
    tick();
    chk("rst_wait_start", bus.eng_start, 1);
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_rsp", bus.rsp_valid, 0);
    chk("rst_mid_abort", bus.eng_abort, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_tcnt", bus.timeout_cnt, 0);
    tick();
    rst_n = 1'b1;
    last_g = N - 1;
    exp_tcnt = 0;
    rsp_cyc = -1;
    run_xfer(4, 32'h0F0F_0F0F, 1'b1, 1'b0, k);
    chk("post_rst_slot", k, 0);
    for (int it = 0; it < 30; it++) begin
      bus.req_valid = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) slot_data[i] = $urandom;
      set_data();
      run_xfer(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
               $urandom, 1'($urandom_range(0, 1)), 1'b0, k);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
